// File: rtl/instruction_memory_sync.sv
// Synchronous-read instruction memory with a streaming loader and fault reporting.
// Optional macro IMEM_BOOT_VECTOR_EN hard-wires word indices 0..2 as read-only jump vectors.
//
// state | meaning
// RUN   | fetches served from memory, one-cycle latency
// LOAD  | loader writes words at ptr, fetch outputs forced to NOP
module instruction_memory_sync #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  fetch_stall,
  input  logic [31:0]           pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic                  instr_fault,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_end,
  output logic                  ld_ready,
  output logic [ADDR_WIDTH:0]   ld_count,
  output logic                  ld_overflow,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH:0]   ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic                  addr_fault;
  logic                  wr_en;
  logic                  wr_ok;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_pc_sup;

  // pc[31] is the supervisor bit; it takes no part in indexing or range checks
  assign unused_pc_sup = pc[31];

  assign idx        = pc[ADDR_WIDTH+1:2];
  assign addr_fault = (pc[1:0] != 2'b00) || (pc[30:ADDR_WIDTH+2] != '0);

  assign busy     = (state == ST_LOAD);
  // ptr never exceeds DEPTH, so its MSB alone marks the full condition
  assign ld_ready = busy && !ptr[ADDR_WIDTH];
  assign wr_en    = ld_valid && ld_ready;
  assign wr_idx   = ptr[ADDR_WIDTH-1:0];

`ifdef IMEM_BOOT_VECTOR_EN
  assign wr_ok = (wr_idx > ADDR_WIDTH'(2));

  always_comb begin
    rd_word = mem[idx];
    case (idx)
      ADDR_WIDTH'(0): rd_word = DATA_WIDTH'(32'h08000010);
      ADDR_WIDTH'(1): rd_word = DATA_WIDTH'(32'h08000060);
      ADDR_WIDTH'(2): rd_word = DATA_WIDTH'(32'h080000A0);
      default:        rd_word = mem[idx];
    endcase
  end
`else
  assign wr_ok   = 1'b1;
  assign rd_word = mem[idx];
`endif

  // Array has no reset: loaded contents survive a reset
  always_ff @(posedge clk) begin
    if (reset && wr_en && wr_ok) begin
      mem[wr_idx] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_RUN;
      ptr         <= '0;
      ld_count    <= '0;
      ld_overflow <= 1'b0;
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      instr_fault <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (ld_start) begin
            state       <= ST_LOAD;
            ptr         <= '0;
            ld_count    <= '0;
            ld_overflow <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (wr_en) begin
            ptr      <= ptr + 1'b1;
            ld_count <= ld_count + 1'b1;
          end else if (ld_valid) begin
            ld_overflow <= 1'b1;
          end
          if (ld_end) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_RUN;
      endcase

      if (state == ST_LOAD) begin
        instr       <= NOP_WORD;
        instr_valid <= 1'b0;
        instr_fault <= 1'b0;
      end else if (!fetch_stall) begin
        if (fetch_req) begin
          instr       <= addr_fault ? NOP_WORD : rd_word;
          instr_valid <= 1'b1;
          instr_fault <= addr_fault;
        end else begin
          instr       <= NOP_WORD;
          instr_valid <= 1'b0;
          instr_fault <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Scoreboard bench for instruction_memory_sync: the driver queues expected fetch results,
// a negedge monitor pops and compares whenever instr_valid is high.
module tb_instruction_memory_sync;

  localparam logic [31:0] NOP = 32'h00000000;

  typedef struct {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic        fetch_stall = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_fault;
  logic        ld_start = 1'b0;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic        ld_end = 1'b0;
  logic        ld_ready;
  logic [8:0]  ld_count;
  logic        ld_overflow;
  logic        busy;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];
  exp_t last_exp;
  logic [31:0] model [256];
  int   tptr = 0;

  instruction_memory_sync #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_stall(fetch_stall), .pc(pc),
    .instr(instr), .instr_valid(instr_valid), .instr_fault(instr_fault),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_end(ld_end),
    .ld_ready(ld_ready), .ld_count(ld_count), .ld_overflow(ld_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
`ifdef IMEM_BOOT_VECTOR_EN
    if (i == 0) return 32'h08000010;
    if (i == 1) return 32'h08000060;
    if (i == 2) return 32'h080000A0;
`endif
    return model[i];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    tptr = 0;
  endtask

  task automatic end_load();
    ld_end = 1'b1;
    step();
    ld_end = 1'b0;
  endtask

  task automatic ld_word(input logic [31:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    if (tptr < 256) begin
      model[tptr] = d;
      tptr++;
    end
    step();
    ld_valid = 1'b0;
  endtask

  // exp_fault is hand-derived per vector; a stalled cycle re-expects the held result
  task automatic fetch(input logic [31:0] a, input logic stall, input logic exp_fault);
    exp_t e;
    fetch_req   = 1'b1;
    fetch_stall = stall;
    pc          = a;
    if (stall) begin
      e = last_exp;
    end else begin
      e.fault = exp_fault;
      e.instr = exp_fault ? NOP : exp_word(int'(a[9:2]));
    end
    last_exp = e;
    sb_q.push_back(e);
    step();
  endtask

  task automatic idle();
    fetch_req   = 1'b0;
    fetch_stall = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (instr_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got instr %h with no fetch outstanding", instr);
        end else begin
          e = sb_q.pop_front();
          chk("fetch_instr", instr, e.instr);
          chk("fetch_fault", {31'b0, instr_fault}, {31'b0, e.fault});
        end
      end else begin
        chk("idle_valid", {31'b0, instr_valid}, 32'd0);
        chk("idle_instr", instr, NOP);
        chk("idle_fault", {31'b0, instr_fault}, 32'd0);
      end
    end
  end

  initial begin
    last_exp.instr = NOP;
    last_exp.fault = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = '0;

    reset = 1'b0;
    step();
    step();
    chk("rst_instr", instr, NOP);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_fault", {31'b0, instr_fault}, 32'd0);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_ld_count", {23'b0, ld_count}, 32'd0);
    chk("rst_ld_overflow", {31'b0, ld_overflow}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // load then fetch
    start_load();
    chk("load_busy", {31'b0, busy}, 32'd1);
    chk("load_ready", {31'b0, ld_ready}, 32'd1);
    ld_word(32'h3C0D4000);
    ld_word(32'hADA00008);
    ld_word(32'h00000000);
    ld_word(32'h0800001A);
    end_load();
    chk("load_count", {23'b0, ld_count}, 32'd4);
    chk("load_busy_fall", {31'b0, busy}, 32'd0);
    fetch(32'h00000004, 1'b0, 1'b0);
    idle();

    // stall hold
    fetch(32'h00000008, 1'b0, 1'b0);
    fetch(32'h0000000C, 1'b1, 1'b0);
    fetch(32'h0000000C, 1'b0, 1'b0);
    idle();

    // faults and supervisor bit
    fetch(32'h00000002, 1'b0, 1'b1);
    fetch(32'h00000400, 1'b0, 1'b1);
    fetch(32'h80000004, 1'b0, 1'b0);
    fetch(32'h0000000E, 1'b0, 1'b1);
    fetch(32'h0000000C, 1'b0, 1'b0);
    idle();

    // fill to capacity, then one word too many
    start_load();
    for (int i = 0; i < 256; i++) ld_word(32'hA5000000 | 32'(i));
    chk("full_ready", {31'b0, ld_ready}, 32'd0);
    chk("full_count", {23'b0, ld_count}, 32'd256);
    chk("full_no_ovf_yet", {31'b0, ld_overflow}, 32'd0);
    ld_valid = 1'b1;
    ld_data  = 32'hDEADBEEF;
    step();
    ld_valid = 1'b0;
    chk("ovf_set", {31'b0, ld_overflow}, 32'd1);
    chk("ovf_count_hold", {23'b0, ld_count}, 32'd256);
    end_load();
    chk("ovf_sticky_run", {31'b0, ld_overflow}, 32'd1);
    chk("ovf_count_run", {23'b0, ld_count}, 32'd256);
    fetch(32'h00000000, 1'b0, 1'b0);
    fetch(32'h00000010, 1'b0, 1'b0);
    fetch(32'h000003FC, 1'b0, 1'b0);
    idle();

    // reset in the middle of a load
    start_load();
    chk("ovf_cleared", {31'b0, ld_overflow}, 32'd0);
    chk("restart_count", {23'b0, ld_count}, 32'd0);
    ld_word(32'h11111111);
    ld_word(32'h22222222);
    chk("mid_count", {23'b0, ld_count}, 32'd2);
    reset = 1'b0;
    step();
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_count", {23'b0, ld_count}, 32'd0);
    chk("midrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("midrst_ready", {31'b0, ld_ready}, 32'd0);
    reset = 1'b1;
    fetch(32'h00000004, 1'b0, 1'b0);
    fetch(32'h00000008, 1'b0, 1'b0);
    idle();

    // low words: ordinary RAM by default, read-only vectors with IMEM_BOOT_VECTOR_EN
    start_load();
    ld_word(32'h12345678);
    ld_word(32'hFFFFFFFF);
    end_load();
    chk("boot_count", {23'b0, ld_count}, 32'd2);
    fetch(32'h00000004, 1'b0, 1'b0);
    fetch(32'h00000000, 1'b0, 1'b0);
    idle();
    idle();

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_memory_sync.md
Name: instruction_memory_sync

Overview:
Parametrised, synchronous-read instruction memory for the pipelined MIPS core; successor to the combinational word-indexed ROM.
- Takes a byte PC and returns the instruction one cycle later, with stall hold and fault reporting.
- Includes a streaming loader port so programs are written at run time rather than hard-coded.
- Sits between the PC register and the IF/ID pipeline register.

Parameters:
ADDR_WIDTH, 8, word-index width; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 32, instruction word width
NOP_WORD, 32'h00000000, value driven when no valid instruction is present

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
fetch_req  input  1  request a fetch at pc this cycle
fetch_stall  input  1  hold current output (pipeline stall)
pc  input  32  byte address; pc[31] is the supervisor bit
instr  output  DATA_WIDTH  fetched instruction
instr_valid  output  1  instr is a fetch result
instr_fault  output  1  fetch address misaligned or out of range
ld_start  input  1  enter load mode
ld_valid  input  1  ld_data is valid
ld_data  input  DATA_WIDTH  word to write at the load pointer
ld_end  input  1  leave load mode
ld_ready  output  1  loader can accept a word this cycle
ld_count  output  ADDR_WIDTH+1  words written in the current/last load
ld_overflow  output  1  sticky: ld_valid arrived while memory was full
busy  output  1  high while in LOAD

Behaviour:
- Single clock domain. Reset is synchronous and active-low: sampled on the clk edge when reset==0.
- Reset values:
  - instr = NOP_WORD; instr_valid = 0; instr_fault = 0.
  - ld_ready = 0; ld_count = 0; ld_overflow = 0; busy = 0.
  - state = RUN.
  - Memory array contents are NOT cleared.
- Address decode:
  - idx = pc[ADDR_WIDTH+1:2]. pc[31] is ignored for indexing.
  - fault = (pc[1:0] != 0) OR (pc[30:ADDR_WIDTH+2] != 0).
- State machine, states RUN and LOAD:
  - RUN -> LOAD on ld_start==1. Load pointer ptr <= 0, ld_count <= 0, ld_overflow <= 0.
  - LOAD -> RUN on ld_end==1. If ld_valid && ld_ready in the same cycle, that word is written before exit.
  - ld_start while already in LOAD: ignored.
  - ld_end while in RUN: ignored.
- Fetch in RUN, latency 1 cycle:
  - fetch_stall==1: instr, instr_valid and instr_fault hold. Stall has priority over fetch_req.
  - fetch_req==1, stall==0, no fault: next cycle instr = mem[idx], instr_valid = 1, instr_fault = 0.
  - fetch_req==1, stall==0, fault: next cycle instr = NOP_WORD, instr_valid = 1, instr_fault = 1.
  - fetch_req==0, stall==0: next cycle instr = NOP_WORD, instr_valid = 0, instr_fault = 0.
- Loader in LOAD:
  - ld_ready = (ptr < DEPTH).
  - On ld_valid && ld_ready: mem[ptr] <= ld_data; ptr++; ld_count++.
  - Full state (ptr == DEPTH): ld_ready = 0. An ld_valid is dropped and sets ld_overflow (sticky until next ld_start or reset). ptr does not wrap.
  - Fetch outputs are forced to instr = NOP_WORD, instr_valid = 0, instr_fault = 0 one cycle after entering LOAD, and stay there while busy. fetch_req is ignored in LOAD.
  - First fetch after LOAD->RUN reads the newly written contents (write-before-read ordering across the transition).
- ld_count retains its final value in RUN until the next ld_start.
- Reset mid-load: returns to RUN with ptr = 0. Words already written remain in memory.

Optional Feature:
Macro IMEM_BOOT_VECTOR_EN.
- Defined: word indices 0, 1 and 2 are hard-wired read-only vectors: 32'h08000010 (j reset entry), 32'h08000060 (j interrupt), 32'h080000A0 (j error).
  - Fetches of idx 0..2 return these constants.
  - Loader writes to idx 0..2 are accepted (ptr and ld_count advance) but leave the vectors unchanged.
- Undefined: idx 0..2 are ordinary RAM words.

Test Plan:
- Load then fetch: reset=0 for 2 cycles; ld_start; stream 4 words 32'h3C0D4000, 32'hADA00008, 32'h00000000, 32'h0800001A; ld_end -> ld_count==4, busy falls. Then pc=32'h00000004 with fetch_req -> next cycle instr==32'hADA00008, instr_valid=1.
- Stall hold: fetch pc=0x8 then pc=0xC with fetch_stall=1 on the second cycle -> instr stays the 0x8 word, valid stays 1. Release stall -> 0xC word one cycle later.
- Faults: pc=32'h00000002 -> instr_fault=1, instr=NOP_WORD, valid=1. pc=32'h00000400 (ADDR_WIDTH=8) -> fault=1. pc=32'h80000004 -> no fault, returns word 1.
- Overflow: ADDR_WIDTH=2; stream 5 words -> ld_ready low after 4 writes; ld_count==4; ld_overflow=1; word 0 unchanged by the 5th. Next ld_start clears ld_overflow.
- Reset mid-load: write 2 words, assert reset -> busy=0, ld_count=0, instr_valid=0. Fetch of idx 1 returns the 2nd word written.
- IMEM_BOOT_VECTOR_EN defined: load 32'hFFFFFFFF at idx 1 -> fetch pc=0x4 returns 32'h08000060.
